activation_deriv: RTL and testbench

//  Backward-pass partner of the sigmoid activation unit. Takes a stored activation output y = f(x) and an error term e.

---
 rtl/activation_pkg.sv | 8 +
 rtl/activation_deriv_mult.sv | 42 ++++
 rtl/activation_deriv.sv | 80 ++++++++
 tb/tb_activation_deriv.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/activation_pkg.sv
// activation_pkg: shared state encoding and fixed-point constants for the activation backward path
package activation_pkg;
  typedef enum logic [1:0] {IDLE, MUL_D, MUL_E, DONE} deriv_state_t;
  localparam int FRAC_Y_DEF = 12;
  localparam logic [15:0] ONE_Q412 = 16'h1000;
  localparam logic [14:0] SM_MAG_MAX = 15'h7FFF;
  localparam int HALF_LSB = 1 << (FRAC_Y_DEF - 1);
endpackage

// File: rtl/activation_deriv_mult.sv
// serial_mult: unsigned shift-add multiplier, one partial product per cycle, done in the DATA_W-th cycle
module serial_mult #(
  parameter int DATA_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_W-1:0]     a,
  input  logic [DATA_W-1:0]     b,
  output logic                  done,
  output logic [2*DATA_W-1:0]   product
);
  localparam int CW = $clog2(DATA_W);
  logic [2*DATA_W-1:0] acc, a_sh;
  logic [DATA_W-1:0] b_sh;
  logic [CW-1:0] cnt;
  logic run;
  // product includes the current partial so it is complete when done is high
  assign product = acc + (b_sh[0] ? a_sh : '0);
  assign done = run && cnt == CW'(DATA_W - 1);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
      a_sh <= '0;
      b_sh <= '0;
      cnt <= '0;
      run <= 1'b0;
    end else if (start) begin
      acc <= '0;
      a_sh <= {{DATA_W{1'b0}}, a};
      b_sh <= b;
      cnt <= '0;
      run <= 1'b1;
    end else if (run) begin
      acc <= product;
      a_sh <= a_sh << 1;
      b_sh <= b_sh >> 1;
      cnt <= cnt + 1'b1;
      run <= !done;
    end
  end
endmodule

// File: rtl/activation_deriv.sv
// activation_deriv: backprop delta = e * y * (1 - y) using one shared serial multiplier.
// Build option DERIV_ROUND_EN: round-to-nearest on both fixed-point shifts instead of truncation.
module activation_deriv
  import activation_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int FRAC_Y = FRAC_Y_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] y_in,
  input  logic [DATA_W-1:0] err_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] delta_out,
  output logic              busy
);
  localparam int PW = 2 * DATA_W;
  localparam int SW = PW - FRAC_Y;
`ifdef DERIV_ROUND_EN
  localparam logic [PW-1:0] RND = PW'(HALF_LSB);
`else
  localparam logic [PW-1:0] RND = '0;
`endif
  deriv_state_t state;
  logic [DATA_W-1:0] ys, y_cl, ma, mb;
  logic [DATA_W-2:0] err_mag, mag_out;
  logic sign, start_q, mult_start, mult_done;
  logic [PW-1:0] prod, rounded;
  logic [SW-1:0] shifted;
  assign y_cl = (y_in > ONE_Q412) ? ONE_Q412 : y_in;
  assign rounded = prod + RND;
  assign shifted = rounded[PW-1:FRAC_Y];
  assign mag_out = (shifted > SW'(SM_MAG_MAX)) ? SM_MAG_MAX : shifted[DATA_W-2:0];
  // the second multiply is launched straight from the first one's finished product
  assign mult_start = start_q || (state == MUL_D && mult_done);
  assign ma = start_q ? ys : {1'b0, err_mag};
  assign mb = start_q ? ONE_Q412 - ys : shifted[DATA_W-1:0];
  assign in_ready = state == IDLE;
  assign out_valid = state == DONE;
  assign busy = state != IDLE;
  serial_mult #(.DATA_W(DATA_W)) u_mult (
    .clk(clk),
    .rst(rst),
    .start(mult_start),
    .a(ma),
    .b(mb),
    .done(mult_done),
    .product(prod)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      ys <= '0;
      sign <= 1'b0;
      err_mag <= '0;
      start_q <= 1'b0;
      delta_out <= '0;
    end else begin
      start_q <= 1'b0;
      case (state)
        IDLE: if (in_valid) begin
          ys <= y_cl;
          sign <= err_in[DATA_W-1];
          err_mag <= err_in[DATA_W-2:0];
          start_q <= 1'b1;
          state <= MUL_D;
        end
        MUL_D: if (mult_done) state <= MUL_E;
        MUL_E: if (mult_done) begin
          delta_out <= {sign && mag_out != '0, mag_out};
          state <= DONE;
        end
        DONE: if (out_ready) state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_activation_deriv.sv
// tb_activation_deriv: randomized and directed checks of activation_deriv against an arithmetic reference model
module tb_activation_deriv;
  logic clk = 1'b0;
  logic rst, in_valid, in_ready, out_valid, out_ready, busy;
  logic [15:0] y_in, err_in, delta_out;
  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  logic [15:0] exp_q[$];
  int due_q[$];
  logic [15:0] last_out = '0;

  activation_deriv dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .y_in(y_in), .err_in(err_in), .out_valid(out_valid), .out_ready(out_ready),
    .delta_out(delta_out), .busy(busy)
  );

  always #5 clk = ~clk;

`ifdef DERIV_ROUND_EN
  localparam longint RB = 2048;
  localparam logic [15:0] EXP_TINY = 16'h0008;
`else
  localparam longint RB = 0;
  localparam logic [15:0] EXP_TINY = 16'h0000;
`endif

  function automatic logic [15:0] model(input logic [15:0] y, input logic [15:0] e);
    longint ys, d, m;
    ys = (y > 16'h1000) ? 4096 : longint'(y);
    d = (ys * (4096 - ys) + RB) / 4096;
    m = (longint'(e[14:0]) * d + RB) / 4096;
    if (m > 32767) m = 32767;
    return {e[15] && m != 0, m[14:0]};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // reference: one operand pair in flight, result valid 33 edges after accept
  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      exp_q.delete();
      due_q.delete();
      last_out = '0;
    end else if (in_valid && exp_q.size() == 0) begin
      exp_q.push_back(model(y_in, err_in));
      due_q.push_back(cyc + 33);
    end else if (exp_q.size() > 0 && cyc - 1 >= due_q[0] && out_ready) begin
      void'(exp_q.pop_front());
      void'(due_q.pop_front());
    end
  end

  always @(negedge clk) begin
    logic ev, er;
    ev = !rst && exp_q.size() > 0 && cyc >= due_q[0];
    er = rst || exp_q.size() == 0;
    if (ev) last_out = exp_q[0];
    chk("out_valid", 32'(out_valid), 32'(ev));
    chk("in_ready", 32'(in_ready), 32'(er));
    chk("busy", 32'(busy), 32'(!er));
    chk("delta_out", 32'(delta_out), rst ? 32'h0 : 32'(last_out));
  end

  task automatic op(input logic [15:0] y, input logic [15:0] e, input logic [15:0] exp, input int stall);
    int n, lat;
    logic [15:0] held;
    y_in = y;
    err_in = e;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    out_ready = stall == 0;
    @(negedge clk);
    lat = 0;
    while (!out_valid && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    chk("latency", 32'(lat), 32'd33);
    chk("result", 32'(delta_out), 32'(exp));
    held = delta_out;
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      chk("stall_hold", 32'(delta_out), 32'(held));
      chk("stall_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
  endtask

  initial begin
    int seen;
    logic [15:0] ry, re;
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    y_in = '0;
    err_in = '0;
    chk("model_quarter", 32'(model(16'h0800, 16'h0100)), 32'h0040);
    chk("model_neg", 32'(model(16'h0800, 16'h8200)), 32'h8080);
    chk("model_clamp", 32'(model(16'h1400, 16'h8300)), 32'h0000);
    chk("model_tiny", 32'(model(16'h0001, 16'h7FFF)), 32'(EXP_TINY));
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_ready", 32'(in_ready), 32'd1);
    chk("reset_valid", 32'(out_valid), 32'd0);
    op(16'h0800, 16'h0100, 16'h0040, 0);
    op(16'h0800, 16'h8200, 16'h8080, 0);
    op(16'h1000, 16'h8300, 16'h0000, 0);
    op(16'h1400, 16'h8300, 16'h0000, 0);
    op(16'h0001, 16'h7FFF, EXP_TINY, 0);
    op(16'h0800, 16'h0100, 16'h0040, 10);
    op(16'h0C00, 16'h8100, model(16'h0C00, 16'h8100), 0);
    // abort during the second multiply
    y_in = 16'h0800;
    err_in = 16'h0100;
    in_valid = 1'b1;
    seen = 0;
    while (!in_ready && seen < 200) begin
      @(negedge clk);
      seen++;
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (22) @(negedge clk);
    #2 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("abort_ready", 32'(in_ready), 32'd1);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_valid", 32'(out_valid), 32'd0);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      seen = seen | int'(out_valid);
    end
    chk("abort_no_result", 32'(seen), 32'd0);
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0: ry = 16'($urandom_range(0, 16'h1000));
        1: ry = 16'($urandom);
        2: ry = 16'h0FF8 + 16'($urandom_range(0, 16));
        default: ry = 16'($urandom_range(0, 8));
      endcase
      re = 16'($urandom);
      op(ry, re, model(ry, re), $urandom_range(0, 3));
    end
    repeat (4) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
